cp_symbol_reader: RTL and testbench
===================================

Name: cp_symbol_reader

Overview:
- Reads one 64-sample OFDM symbol out of the 64-entry, 13-bit symbol buffer through its registered read port. Streams the symbol out with cyclic-prefix insertion: the last CP_LEN samples come first, then all 64 samples.
- Sits between the symbol buffer (the IFFT output store) and the TX framing/DAC path. Provides a valid/ready output stream with full backpressure support.

Parameters:
- CP_LEN, 16, cyclic prefix length in samples; legal range 0..63.
- DW, 13, sample width; must match the buffer data width.
- AW, 6, buffer address width; symbol length is 2**AW = 64.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to read out one symbol; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the final output word is accepted.
- mem_rd_en  output  1  buffer read enable.
- mem_rd_addr  output  AW  buffer read address.
- mem_rd_data  input  DW  buffer read data; valid the cycle after mem_rd_en is sampled, and zero otherwise.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DW  output sample.
- out_first  output  1  qualifies the first word of the symbol (the first CP word, or word 0 when CP_LEN=0).
- out_last  output  1  qualifies the final word (address 63 of the body).

Behaviour:
- Reset: async assert clears every register immediately. Reset values: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_first=0, out_last=0. FSM goes to IDLE.
- Read sequence: addresses 64-CP_LEN .. 63, then 0 .. 63. Total words = 64+CP_LEN. Address counter wraps 63->0 naturally in AW bits. A phase flag distinguishes the CP pass from the body pass.
- FSM states:
  - IDLE: start=1 -> RUN, busy=1.
  - RUN: issues reads. After the last address is issued -> DRAIN.
  - DRAIN: no reads. When the output is empty and the final word has been accepted -> IDLE, done=1 for one cycle, busy=0.
- Output staging: 2-entry buffer (output register plus skid). Required because buffer data is present for exactly one cycle (it reads back 0 when not enabled) and must be captured unconditionally.
  - occ = words held + reads in flight (0..2).
  - A read is issued in a cycle only if RUN and (occ - pop) < 2, where pop = out_valid & out_ready.
  - Returning data is always captured. No overwrite, no drop.
- Latency: start sampled at edge E0 -> mem_rd_en=1, addr=64-CP_LEN in cycle E0..E1 -> out_valid=1 after E2, i.e. 2 cycles after start.
  - With out_ready held high: one word per cycle, no bubbles, 64+CP_LEN consecutive valid cycles.
- Stall: while out_valid=1 and out_ready=0, out_data, out_first and out_last are held stable.
- start while busy is ignored. start in the same cycle as done (FSM in IDLE after the done edge) is accepted normally. A start coincident with the DRAIN->IDLE transition is ignored.
- out_first and out_last are each asserted for exactly one accepted word per symbol.
- CP_LEN=0: CP phase skipped, sequence is 0..63, out_first on word 0.
- mem_rd_en=0 whenever not issuing. mem_rd_addr may hold its last value.

Test Plan:
- Reset: rst_n low mid-clock -> all outputs 0 immediately, with no clock edge required; start ignored while rst_n=0.
- Buffer preloaded mem[i]=100+i, CP_LEN=16, out_ready=1, pulse start -> out_valid rises 2 cycles later. 80 consecutive words: 148..163 then 100..163. out_first on the first 148, out_last on the final 163, done one cycle after the last handshake.
- Same preload, out_ready pattern 1,0,1,0 plus one 5-cycle low burst -> identical 80-word sequence with no loss or duplication. Data stable during stalls. Assertion: occ never exceeds 2, and mem_rd_en is never high when (occ - pop) = 2.
- CP_LEN=0 parameter instance, mem[i]=i -> 64 words 0..63, out_first on 0, out_last on 63, done pulse.
- start pulsed at output word 10 while busy -> ignored, exactly 80 words. A second start issued after done returns to IDLE -> a second full 80-word symbol, same order.
- rst_n asserted at output word 30, released, then start -> outputs clear immediately. The new symbol begins again at address 48 with out_first.

Source files
------------

// File: rtl/cp_symbol_reader.sv
// Streams one 64-sample symbol out of the symbol buffer with cyclic-prefix insertion
// (last CP_LEN samples first, then the whole symbol) on a valid/ready output port.
`timescale 1ns/1ps

module cp_symbol_reader #(
  parameter int CP_LEN = 16,
  parameter int DW     = 13,
  parameter int AW     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_first,
  output logic          out_last
);

  localparam logic [AW-1:0] CP_START  = AW'((2 ** AW) - CP_LEN);
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic          HAS_CP    = (CP_LEN != 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        r_state, w_next_state;
  logic [AW-1:0] r_addr;
  logic          r_cp_phase, r_first_pend;
  logic          r_pend, r_pend_first, r_pend_last;
  logic          r_busy, r_done;
  logic          r_out_valid, r_out_first, r_out_last;
  logic [DW-1:0] r_out_data;
  logic          r_skid_valid, r_skid_first, r_skid_last;
  logic [DW-1:0] r_skid_data;

  logic          w_pop, w_issue, w_issue_last, w_room;
  logic [1:0]    w_occ;

  // Occupancy counts held words plus the read whose data is returning this cycle,
  // so every returning word is guaranteed a slot.
  assign w_pop        = r_out_valid & out_ready;
  assign w_occ        = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_pend);
  assign w_room       = (w_occ - 2'(w_pop)) < 2'd2;
  assign w_issue      = (r_state == S_RUN) && w_room;
  assign w_issue_last = !r_cp_phase && (r_addr == LAST_ADDR);

  assign busy        = r_busy;
  assign done        = r_done;
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_addr;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_first   = r_out_first;
  assign out_last    = r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_issue && w_issue_last) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pop && r_out_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_cp_phase   <= 1'b0;
      r_first_pend <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_first <= 1'b0;
      r_pend_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_addr       <= CP_START;
        r_cp_phase   <= HAS_CP;
        r_first_pend <= 1'b1;
        r_busy       <= 1'b1;
      end else if (w_issue) begin
        r_addr       <= r_addr + 1'b1;
        r_first_pend <= 1'b0;
        if (r_addr == LAST_ADDR) r_cp_phase <= 1'b0;
      end
      r_pend       <= w_issue;
      r_pend_first <= w_issue & r_first_pend;
      r_pend_last  <= w_issue & w_issue_last;
      r_done       <= 1'b0;
      if (r_state == S_DRAIN && w_pop && r_out_last) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  // Output register plus skid slot; the skid only fills when a word returns
  // while the output register is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_first <= 1'b0;
      r_skid_last  <= 1'b0;
    end else if (w_pop && r_skid_valid) begin
      r_out_data   <= r_skid_data;
      r_out_first  <= r_skid_first;
      r_out_last   <= r_skid_last;
      r_skid_valid <= r_pend;
      if (r_pend) begin
        r_skid_data  <= mem_rd_data;
        r_skid_first <= r_pend_first;
        r_skid_last  <= r_pend_last;
      end
    end else if (w_pop || !r_out_valid) begin
      r_out_valid <= r_pend;
      if (r_pend) begin
        r_out_data  <= mem_rd_data;
        r_out_first <= r_pend_first;
        r_out_last  <= r_pend_last;
      end
    end else if (r_pend) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= mem_rd_data;
      r_skid_first <= r_pend_first;
      r_skid_last  <= r_pend_last;
    end
  end

endmodule

// File: tb/tb_cp_symbol_reader.sv
// Drives a CP_LEN=16 and a CP_LEN=0 reader side by side from shared controls and
// compares every accepted word against the expected CP-then-body address order.
`timescale 1ns/1ps

module tb_cp_symbol_reader;

  localparam int DW = 13;
  localparam int AW = 6;
  localparam int HIST = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic outReady = 1'b1;

  logic [1:0]    busy, done, memRdEn, outValid, outFirst, outLast;
  logic [AW-1:0] memRdAddr [2];
  logic [DW-1:0] memRdData [2];
  logic [DW-1:0] outData [2];
  logic [DW-1:0] mem [2][64];

  logic [DW-1:0] gotData [2][HIST];
  logic          gotFirst [2][HIST];
  logic          gotLast [2][HIST];
  int gotCount [2] = '{0, 0};
  int doneCount [2] = '{0, 0};
  int lastCyc [2] = '{-10, -10};
  int occ [2] = '{0, 0};
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int readyMode = 0;
  int modeBase = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int CP = (k == 0) ? 16 : 0;

    logic [DW-1:0] prevData;
    logic prevFirst, prevLast;
    logic prevStall = 1'b0;

    cp_symbol_reader #(.CP_LEN(CP), .DW(DW), .AW(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy[k]),
      .done        (done[k]),
      .mem_rd_en   (memRdEn[k]),
      .mem_rd_addr (memRdAddr[k]),
      .mem_rd_data (memRdData[k]),
      .out_valid   (outValid[k]),
      .out_ready   (outReady),
      .out_data    (outData[k]),
      .out_first   (outFirst[k]),
      .out_last    (outLast[k])
    );

    // Registered-read buffer model: data for one cycle after the enable, zero otherwise.
    always @(posedge clk) memRdData[k] <= memRdEn[k] ? mem[k][memRdAddr[k]] : '0;

    always @(negedge clk) begin : collect
      logic hs;
      hs = outValid[k] && outReady;
      if (!rst_n) begin
        occ[k] = 0;
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput($sformatf("stall_valid[%0d]", k), 32'(outValid[k]), 1);
          checkOutput($sformatf("stall_data[%0d]", k), 32'(outData[k]), 32'(prevData));
          checkOutput($sformatf("stall_first[%0d]", k), 32'(outFirst[k]), 32'(prevFirst));
          checkOutput($sformatf("stall_last[%0d]", k), 32'(outLast[k]), 32'(prevLast));
        end
        prevStall = outValid[k] && !outReady;
        prevData  = outData[k];
        prevFirst = outFirst[k];
        prevLast  = outLast[k];
        if (hs) begin
          gotData[k][gotCount[k] % HIST]  = outData[k];
          gotFirst[k][gotCount[k] % HIST] = outFirst[k];
          gotLast[k][gotCount[k] % HIST]  = outLast[k];
          gotCount[k]++;
          if (outLast[k]) lastCyc[k] = cyc;
        end
        if (done[k]) begin
          checkOutput($sformatf("done_timing[%0d]", k), cyc, lastCyc[k] + 1);
          doneCount[k]++;
        end
        checkOutput($sformatf("occ_max[%0d]", k), 32'(occ[k] <= 2), 1);
        checkOutput($sformatf("rd_when_full[%0d]", k), 32'(memRdEn[k] && (occ[k] - int'(hs) == 2)), 0);
        occ[k] = occ[k] + int'(memRdEn[k]) - int'(hs);
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = alternating with a 5-cycle low burst, 2 = random.
  initial begin : readyDriver
    int ph;
    forever begin
      @(posedge clk);
      #1;
      ph = cyc - modeBase;
      case (readyMode)
        1:       outReady = (ph >= 20 && ph < 25) ? 1'b0 : (ph % 2 == 0);
        2:       outReady = ($urandom % 4) != 0;
        default: outReady = 1'b1;
      endcase
    end
  end

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic checkSymbol(input int k, input int base, input int dataBase);
    int cp;
    int total;
    int got;
    cp    = (k == 0) ? 16 : 0;
    total = cp + 64;
    got   = gotCount[k] - base;
    checkOutput($sformatf("word_count[%0d]", k), got, total);
    for (int n = 0; n < total && n < got; n++) begin
      int addr;
      int idx;
      addr = (n < cp) ? (64 - cp + n) : (n - cp);
      idx  = (base + n) % HIST;
      checkOutput($sformatf("data[%0d][%0d]", k, n), 32'(gotData[k][idx]), dataBase + addr);
      checkOutput($sformatf("first[%0d][%0d]", k, n), 32'(gotFirst[k][idx]), 32'(n == 0));
      checkOutput($sformatf("last[%0d][%0d]", k, n), 32'(gotLast[k][idx]), 32'(n == total - 1));
    end
  endtask

  task automatic applyStimulus(input int mode, input bit startWhileBusy, input bit checkLatency);
    int b0, b1, d0, d1, n;
    b0 = gotCount[0];
    b1 = gotCount[1];
    d0 = doneCount[0];
    d1 = doneCount[1];
    readyMode = mode;
    modeBase = cyc;
    pulseStart();
    checkOutput("busy_after_start[0]", 32'(busy[0]), 1);
    checkOutput("busy_after_start[1]", 32'(busy[1]), 1);
    if (checkLatency) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        #1;
        checkOutput($sformatf("latency_valid[0][%0d]", c), 32'(outValid[0]), 32'(c == 2));
        checkOutput($sformatf("latency_valid[1][%0d]", c), 32'(outValid[1]), 32'(c == 2));
      end
    end
    if (startWhileBusy) begin
      n = 0;
      while (gotCount[0] - b0 < 10 && n < 500) begin
        @(posedge clk);
        n++;
      end
      checkOutput("reach_word10", 32'(n < 500), 1);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    n = 0;
    while ((doneCount[0] <= d0 || doneCount[1] <= d1) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("done_wait", 32'(n < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses[0]", doneCount[0] - d0, 1);
    checkOutput("done_pulses[1]", doneCount[1] - d1, 1);
    checkOutput("busy_idle[0]", 32'(busy[0]), 0);
    checkOutput("busy_idle[1]", 32'(busy[1]), 0);
    checkSymbol(0, b0, 100);
    checkSymbol(1, b1, 0);
  endtask

  task automatic checkAllClear(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 0);
      checkOutput($sformatf("%s_done[%0d]", tag, k), 32'(done[k]), 0);
      checkOutput($sformatf("%s_rd_en[%0d]", tag, k), 32'(memRdEn[k]), 0);
      checkOutput($sformatf("%s_rd_addr[%0d]", tag, k), 32'(memRdAddr[k]), 0);
      checkOutput($sformatf("%s_valid[%0d]", tag, k), 32'(outValid[k]), 0);
      checkOutput($sformatf("%s_data[%0d]", tag, k), 32'(outData[k]), 0);
      checkOutput($sformatf("%s_first[%0d]", tag, k), 32'(outFirst[k]), 0);
      checkOutput($sformatf("%s_last[%0d]", tag, k), 32'(outLast[k]), 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    int b0, n;
    for (int i = 0; i < 64; i++) begin
      mem[0][i] = DW'(100 + i);
      mem[1][i] = DW'(i);
    end
    #1 rst_n = 1'b0;
    #2;
    checkAllClear("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(2, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);

    // Abort a symbol at output word 30 with a mid-cycle reset.
    readyMode = 0;
    b0 = gotCount[0];
    pulseStart();
    n = 0;
    while (gotCount[0] - b0 < 30 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_word30", 32'(n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    checkAllClear("midreset");
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("start_in_reset_busy[0]", 32'(busy[0]), 0);
    checkOutput("start_in_reset_busy[1]", 32'(busy[1]), 0);
    start = 1'b0;
    #2 rst_n = 1'b1;

    applyStimulus(2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
